// File: rtl/formula_res_buffer.sv
// Result buffer behind the formula calculator: a FWFT FIFO with valid/ready
// output plus saturating drop/overflow status counters.
module formula_res_buffer #(
    parameter int LEN      = 8,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16,
    parameter int DROP_OVF = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3*LEN-1:0]         in_res,
    input  logic                     in_overflow,
    input  logic                     in_vld,
    output logic [3*LEN-1:0]         out_res,
    output logic                     out_overflow,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         ovf_cnt,
    input  logic                     clr_cnt
);

    localparam int W  = 3 * LEN;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic FILT = (DROP_OVF != 0);

    logic [W:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] level_nxt;
    logic [W:0]    head;

    logic pop;
    logic store;
    logic push;
    logic drop;
    logic ovf_hit;

    assign pop     = ~empty & out_rdy;
    assign store   = in_vld & ~(FILT & in_overflow);
    assign push    = store & (~full | pop);
    assign drop    = store & full & ~pop;
    assign ovf_hit = in_vld & in_overflow;

    // Head is presented straight from storage; zeroed while nothing is held.
    assign head         = mem[rd_ptr];
    assign out_vld      = ~empty;
    assign out_res      = empty ? '0 : head[W-1:0];
    assign out_overflow = empty ? 1'b0 : head[W];

    always_comb begin
        level_nxt = level;
        if (push & ~pop)
            level_nxt = level + 1'b1;
        else if (pop & ~push)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_overflow, in_res};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (drop && !(&drop_cnt))
                drop_cnt <= drop_cnt + 1'b1;
            if (ovf_hit && !(&ovf_cnt))
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule
